// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared MIPS data-memory access definitions
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_t;

    localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEFAULT_ABORT_DATA     = 32'hDEADBEEF;
    localparam int          WAIT_CNT_WIDTH         = 16;

    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// rtl/mem_access_ctrl_load_align.sv - byte lane select and extension for loads
module load_align (
    input  logic [31:0] wordIn,
    input  logic [1:0]  lane,
    input  logic        isByte,
    input  logic        signExtend,
    output logic [31:0] dataOut
);

    logic [7:0] laneByte;

    // Lane 0 is the least significant byte of the memory word.
    always_comb begin
        laneByte = 8'h00;
        case (lane)
            2'd0: laneByte = wordIn[7:0];
            2'd1: laneByte = wordIn[15:8];
            2'd2: laneByte = wordIn[23:16];
            2'd3: laneByte = wordIn[31:24];
            default: laneByte = 8'h00;
        endcase

        if (!isByte) begin
            dataOut = wordIn;
        end else if (signExtend) begin
            dataOut = {{24{laneByte[7]}}, laneByte};
        end else begin
            dataOut = {24'h000000, laneByte};
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data memory handshake with stall and timeout
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] ABORT_DATA     = DEFAULT_ABORT_DATA
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic        LbIn,
    input  logic        LoadExtendedIn,
    input  logic [31:0] AddressIn,
    input  logic [31:0] WriteDataIn,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic [31:0] ReadDataOut,
    output logic        ReadValid,
    output logic        Stall,
    output logic        Timeout
);

    localparam logic [WAIT_CNT_WIDTH-1:0] TIMEOUT_LAST = WAIT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    memState_t                 state;
    logic [WAIT_CNT_WIDTH-1:0] waitCnt;
    logic [31:0]               latchedAddr;
    logic [31:0]               latchedData;
    logic                      latchedByte;
    logic                      latchedExt;
    logic                      latchedWrite;
    logic [31:0]               alignedData;

    load_align u_load_align (
        .wordIn     (MemRData),
        .lane       (latchedAddr[1:0]),
        .isByte     (latchedByte),
        .signExtend (latchedExt),
        .dataOut    (alignedData)
    );

    assign MemReq   = (state == WAIT);
    assign MemWe    = MemReq && latchedWrite;
    assign MemAddr  = wordAlign(latchedAddr);
    assign MemWData = latchedData;

    // The request is seen combinationally so the pipeline freezes in the same cycle it arrives.
    assign Stall = !Rst && ((state == WAIT) || ((state == IDLE) && (MemReadIn || MemWriteIn)));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            waitCnt      <= '0;
            latchedAddr  <= '0;
            latchedData  <= '0;
            latchedByte  <= 1'b0;
            latchedExt   <= 1'b0;
            latchedWrite <= 1'b0;
            ReadDataOut  <= '0;
            ReadValid    <= 1'b0;
            Timeout      <= 1'b0;
        end else begin
            ReadValid <= 1'b0;
            Timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemReadIn || MemWriteIn) begin
                        latchedAddr  <= AddressIn;
                        latchedData  <= WriteDataIn;
                        latchedByte  <= LbIn;
                        latchedExt   <= LoadExtendedIn;
                        // A simultaneous read and write request is serviced as a read.
                        latchedWrite <= MemWriteIn && !MemReadIn;
                        waitCnt      <= '0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (MemAck) begin
                        if (!latchedWrite) begin
                            ReadDataOut <= alignedData;
                            ReadValid   <= 1'b1;
                        end
                        state <= DONE;
                    end else if (waitCnt == TIMEOUT_LAST) begin
                        if (!latchedWrite) begin
                            ReadDataOut <= ABORT_DATA;
                        end
                        Timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized model-checked bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int          TO    = 4;
    localparam logic [31:0] ABORT = 32'hDEADBEEF;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        MemReadIn, MemWriteIn, LbIn, LoadExtendedIn;
    logic [31:0] AddressIn, WriteDataIn;
    logic        MemReq, MemWe, MemAck;
    logic [31:0] MemAddr, MemWData, MemRData, ReadDataOut;
    logic        ReadValid, Stall, Timeout;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .ABORT_DATA(ABORT)) dut (
        .Clk(Clk), .Rst(Rst),
        .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
        .LbIn(LbIn), .LoadExtendedIn(LoadExtendedIn),
        .AddressIn(AddressIn), .WriteDataIn(WriteDataIn),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData),
        .ReadDataOut(ReadDataOut), .ReadValid(ReadValid),
        .Stall(Stall), .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    logic        chkEn = 1'b0;
    logic        expStall, expReq, expWe, expValid, expTimeout;
    logic [31:0] expAddr, expWData, expRdo;
    int          stallCount, validCount, timeoutCount;
    logic [31:0] capAddr, capWData;
    logic        capWe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] loadModel(input logic [31:0] w, input logic [31:0] a,
                                              input bit lb, input bit ext);
        logic [7:0] b;
        if (!lb) return w;
        b = 8'(w >> (8 * a[1:0]));
        return ext ? {{24{b[7]}}, b} : {24'h0, b};
    endfunction

    always @(negedge Clk) begin
        if (chkEn) begin
            chk("Stall", 32'(Stall), 32'(expStall));
            chk("MemReq", 32'(MemReq), 32'(expReq));
            chk("ReadValid", 32'(ReadValid), 32'(expValid));
            chk("Timeout", 32'(Timeout), 32'(expTimeout));
            chk("ReadDataOut", ReadDataOut, expRdo);
            if (expReq) begin
                chk("MemWe", 32'(MemWe), 32'(expWe));
                chk("MemAddr", MemAddr, expAddr);
                chk("MemWData", MemWData, expWData);
            end
            if (MemReq === 1'b1) begin
                capAddr  = MemAddr;
                capWData = MemWData;
                capWe    = MemWe;
            end
            stallCount   += int'(Stall === 1'b1);
            validCount   += int'(ReadValid === 1'b1);
            timeoutCount += int'(Timeout === 1'b1);
        end
    end

    task automatic clearCounts();
        stallCount = 0; validCount = 0; timeoutCount = 0;
    endtask

    // ackAt: WAIT cycle (1-based) in which MemAck arrives; 0 or >TO means never.
    task automatic access(input bit rd, input bit wr, input bit lb, input bit ext,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int ackAt, input bit ackNoise);
        bit isRead = rd;
        bit acked  = (ackAt >= 1) && (ackAt <= TO);
        int nWait  = acked ? ackAt : TO;

        @(posedge Clk); #1;
        MemReadIn = rd; MemWriteIn = wr; LbIn = lb; LoadExtendedIn = ext;
        AddressIn = addr; WriteDataIn = wd;
        MemAck = ackNoise; MemRData = $urandom;
        expStall = 1'b1; expReq = 1'b0; expValid = 1'b0; expTimeout = 1'b0;

        for (int k = 1; k <= nWait; k++) begin
            @(posedge Clk); #1;
            AddressIn = $urandom; WriteDataIn = $urandom;
            LbIn = 1'($urandom); LoadExtendedIn = 1'($urandom);
            MemAck = acked && (k == ackAt);
            MemRData = MemAck ? rdata : $urandom;
            expStall = 1'b1; expReq = 1'b1; expWe = !isRead;
            expAddr = {addr[31:2], 2'b00}; expWData = wd;
        end

        @(posedge Clk); #1;
        MemAck = ackNoise; MemRData = $urandom;
        expStall = 1'b0; expReq = 1'b0;
        expValid = isRead && acked; expTimeout = !acked;
        if (isRead) expRdo = acked ? loadModel(rdata, addr, lb, ext) : ABORT;

        @(posedge Clk); #1;
        MemReadIn = 1'b0; MemWriteIn = 1'b0; MemAck = ackNoise;
        expValid = 1'b0; expTimeout = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; MemReadIn = 1'b1; MemWriteIn = 1'b0; LbIn = 1'b0; LoadExtendedIn = 1'b0;
        AddressIn = 32'h0; WriteDataIn = 32'h0; MemAck = 1'b0; MemRData = 32'h0;
        expStall = 1'b0; expReq = 1'b0; expWe = 1'b0; expValid = 1'b0; expTimeout = 1'b0;
        expAddr = 32'h0; expWData = 32'h0; expRdo = 32'h0;
        capAddr = 32'h0; capWData = 32'h0; capWe = 1'b0;
        clearCounts();

        // Reset held with a request present: Stall must stay low.
        @(posedge Clk); #1;
        chkEn = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; MemReadIn = 1'b0;
        clearCounts();

        // Word load, ack in third WAIT cycle.
        access(1, 0, 0, 0, 32'h104, 32'h5555AAAA, 32'h11223344, 3, 0);
        chk("word_stall_cycles", 32'(stallCount), 32'd4);
        chk("word_valid_pulses", 32'(validCount), 32'd1);
        chk("word_rdo", ReadDataOut, 32'h11223344);

        access(1, 0, 1, 1, 32'h103, 32'h0, 32'h80FF7F01, 1, 1);
        chk("byte_sext", ReadDataOut, 32'hFFFFFF80);
        access(1, 0, 1, 0, 32'h103, 32'h0, 32'h80FF7F01, 2, 1);
        chk("byte_zext", ReadDataOut, 32'h00000080);

        clearCounts();
        access(0, 1, 0, 0, 32'h207, 32'hCAFEBABE, 32'h12345678, 1, 0);
        chk("store_addr", capAddr, 32'h204);
        chk("store_we", 32'(capWe), 32'd1);
        chk("store_wdata", capWData, 32'hCAFEBABE);
        chk("store_no_valid", 32'(validCount), 32'd0);
        chk("store_rdo_kept", ReadDataOut, 32'h00000080);

        clearCounts();
        access(1, 0, 0, 0, 32'h300, 32'h0, 32'h0, 0, 0);
        chk("to_pulses", 32'(timeoutCount), 32'd1);
        chk("to_stall_cycles", 32'(stallCount), 32'd5);
        chk("to_rdo", ReadDataOut, 32'hDEADBEEF);

        access(1, 1, 0, 0, 32'h40C, 32'h77777777, 32'hA5A5A5A5, 2, 0);
        chk("rw_as_read", ReadDataOut, 32'hA5A5A5A5);

        // Reset during the second WAIT cycle, then a late ack.
        clearCounts();
        @(posedge Clk); #1;
        MemReadIn = 1'b1; AddressIn = 32'h500; WriteDataIn = 32'h0; LbIn = 1'b0;
        expStall = 1'b1; expReq = 1'b0;
        @(posedge Clk); #1;
        expStall = 1'b1; expReq = 1'b1; expWe = 1'b0; expAddr = 32'h500; expWData = 32'h0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        expStall = 1'b0; expReq = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0; MemReadIn = 1'b0; MemAck = 1'b1; MemRData = 32'h99999999;
        expStall = 1'b0; expReq = 1'b0; expValid = 1'b0; expTimeout = 1'b0; expRdo = 32'h0;
        @(posedge Clk); #1;
        MemAck = 1'b0;
        @(posedge Clk); #1;
        chk("rst_no_valid", 32'(validCount), 32'd0);
        chk("rst_no_timeout", 32'(timeoutCount), 32'd0);
        chk("rst_rdo", ReadDataOut, 32'h0);

        for (int i = 0; i < 60; i++) begin
            bit rd, wr;
            int sel = $urandom_range(0, 2);
            rd = (sel != 1);
            wr = (sel != 0);
            access(rd, wr, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, TO + 1), 1'($urandom));
        end

        chkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
